// File: rtl/eco32_core_ifu_icu_way_pt_fill_pkg.sv
// Shared IFU definitions for the page-descriptor table refill block.
package eco32_core_ifu_icu_way_pt_fill_pkg;

  localparam int DESC_W          = 36;
  localparam int DESC_ADDR_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } pt_fill_state_e;

endpackage

// File: rtl/eco32_core_ifu_icu_way_pt_fill.sv
// Refill/flush writer for one cache way's page descriptor table.
// Outputs are registered and describe the action of the state held at the previous edge.
module eco32_core_ifu_icu_way_pt_fill
  import eco32_core_ifu_icu_way_pt_fill_pkg::*;
#(
  parameter int PAGE_ADDR_WIDTH = 5,
  parameter int MEM_ADDR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_pt_base,
  input  logic                       flush_req,
  output logic                       flush_ack,
  input  logic                       mis_stb,
  input  logic                       mis_tid,
  input  logic [PAGE_ADDR_WIDTH-1:0] mis_page,
  output logic                       mis_ack,
  output logic                       mis_fault,
  output logic                       mem_req_stb,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                       mem_req_ack,
  input  logic                       mem_rsp_stb,
  input  logic [DESC_W-1:0]          mem_rsp_data,
  input  logic                       mem_rsp_err,
  output logic                       wr_ena,
  output logic                       wr_tid,
  output logic [PAGE_ADDR_WIDTH-1:0] wr_page,
  output logic [DESC_W-1:0]          wr_descriptor,
  output logic                       busy,
  output logic [2:0]                 dbg_state
);

  localparam int CW = PAGE_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST = '1;

  pt_fill_state_e             state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic                       user_q, user_d;
  logic                       done_q, done_d;
  logic                       tid_q, tid_d;
  logic [PAGE_ADDR_WIDTH-1:0] page_q, page_d;
  logic [DESC_W-1:0]          data_q, data_d;
  logic                       err_q, err_d;

  logic                       flush_ack_q, flush_ack_d;
  logic                       mis_ack_q, mis_ack_d;
  logic                       mis_fault_q, mis_fault_d;
  logic                       mem_req_stb_q, mem_req_stb_d;
  logic [MEM_ADDR_WIDTH-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic                       wr_ena_q, wr_ena_d;
  logic                       wr_tid_q, wr_tid_d;
  logic [PAGE_ADDR_WIDTH-1:0] wr_page_q, wr_page_d;
  logic [DESC_W-1:0]          wr_desc_q, wr_desc_d;
  logic                       busy_q, busy_d;

  // Handshakes: mis_stb/flush_req are levels held until their one-cycle ack;
  // the request is ignored in the ack window so a still-high level is not re-taken.
  // mem_req_stb is held until mem_req_ack is seen with it; mem_rsp_stb is a one-cycle strobe.
  logic flush_take;
  logic miss_take;
  assign flush_take = flush_req && !done_q && !flush_ack_q;
  assign miss_take  = mis_stb && !mis_ack_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    user_d         = user_q;
    done_d         = 1'b0;
    tid_d          = tid_q;
    page_d         = page_q;
    data_d         = data_q;
    err_d          = err_q;
    busy_d         = (state_q != ST_IDLE);
    flush_ack_d    = done_q;
    mis_ack_d      = 1'b0;
    mis_fault_d    = 1'b0;
    mem_req_stb_d  = 1'b0;
    mem_req_addr_d = mem_req_addr_q;
    wr_ena_d       = 1'b0;
    wr_tid_d       = wr_tid_q;
    wr_page_d      = wr_page_q;
    wr_desc_d      = wr_desc_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_take || pend_q) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
          user_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (miss_take) begin
          state_d = ST_REQ;
          tid_d   = mis_tid;
          page_d  = mis_page;
        end
      end
      ST_FLUSH: begin
        wr_ena_d               = 1'b1;
        wr_desc_d              = '0;
        {wr_page_d, wr_tid_d}  = cnt_q;
        cnt_d                  = cnt_q + 1'b1;
        // Only a requested sweep is acknowledged; the post-reset sweep is silent.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = user_q;
          user_d  = 1'b0;
        end
      end
      ST_REQ: begin
        pend_d = pend_q | flush_take;
        if (mem_req_stb_q && mem_req_ack) begin
          state_d = ST_WAIT;
        end else begin
          mem_req_stb_d  = 1'b1;
          mem_req_addr_d = cfg_pt_base +
                           (MEM_ADDR_WIDTH'({page_q, tid_q}) << DESC_ADDR_SHIFT);
        end
      end
      ST_WAIT: begin
        pend_d = pend_q | flush_take;
        if (mem_rsp_stb) begin
          state_d = ST_WRITE;
          data_d  = mem_rsp_data;
          err_d   = mem_rsp_err;
        end
      end
      ST_WRITE: begin
        pend_d      = pend_q | flush_take;
        wr_ena_d    = 1'b1;
        wr_tid_d    = tid_q;
        wr_page_d   = page_q;
        wr_desc_d   = err_q ? '0 : data_q;
        mis_ack_d   = 1'b1;
        mis_fault_d = err_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_FLUSH;
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      user_q         <= 1'b0;
      done_q         <= 1'b0;
      tid_q          <= 1'b0;
      page_q         <= '0;
      data_q         <= '0;
      err_q          <= 1'b0;
      flush_ack_q    <= 1'b0;
      mis_ack_q      <= 1'b0;
      mis_fault_q    <= 1'b0;
      mem_req_stb_q  <= 1'b0;
      mem_req_addr_q <= '0;
      wr_ena_q       <= 1'b0;
      wr_tid_q       <= 1'b0;
      wr_page_q      <= '0;
      wr_desc_q      <= '0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      user_q         <= user_d;
      done_q         <= done_d;
      tid_q          <= tid_d;
      page_q         <= page_d;
      data_q         <= data_d;
      err_q          <= err_d;
      flush_ack_q    <= flush_ack_d;
      mis_ack_q      <= mis_ack_d;
      mis_fault_q    <= mis_fault_d;
      mem_req_stb_q  <= mem_req_stb_d;
      mem_req_addr_q <= mem_req_addr_d;
      wr_ena_q       <= wr_ena_d;
      wr_tid_q       <= wr_tid_d;
      wr_page_q      <= wr_page_d;
      wr_desc_q      <= wr_desc_d;
      busy_q         <= busy_d;
    end
  end

  assign flush_ack     = flush_ack_q;
  assign mis_ack       = mis_ack_q;
  assign mis_fault     = mis_fault_q;
  assign mem_req_stb   = mem_req_stb_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign wr_ena        = wr_ena_q;
  assign wr_tid        = wr_tid_q;
  assign wr_page       = wr_page_q;
  assign wr_descriptor = wr_desc_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_eco32_core_ifu_icu_way_pt_fill.sv
// Bench for the page-descriptor refill block: expected table writes and acks are
// queued in issue order and compared against the DUT on every falling edge.
module tb_eco32_core_ifu_icu_way_pt_fill;

  localparam int PAW = 5;
  localparam int MAW = 32;
  localparam int W   = PAW + 1 + 36;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [MAW-1:0] cfg_pt_base = 32'h1000;
  logic           flush_req = 1'b0;
  logic           flush_ack;
  logic           mis_stb = 1'b0;
  logic           mis_tid = 1'b0;
  logic [PAW-1:0] mis_page = '0;
  logic           mis_ack;
  logic           mis_fault;
  logic           mem_req_stb;
  logic [MAW-1:0] mem_req_addr;
  logic           mem_req_ack = 1'b0;
  logic           mem_rsp_stb = 1'b0;
  logic [35:0]    mem_rsp_data = '0;
  logic           mem_rsp_err = 1'b0;
  logic           wr_ena;
  logic           wr_tid;
  logic [PAW-1:0] wr_page;
  logic [35:0]    wr_descriptor;
  logic           busy;
  logic [2:0]     dbg_state;

  eco32_core_ifu_icu_way_pt_fill #(.PAGE_ADDR_WIDTH(PAW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .rst(rst), .cfg_pt_base(cfg_pt_base),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .mis_stb(mis_stb), .mis_tid(mis_tid), .mis_page(mis_page),
    .mis_ack(mis_ack), .mis_fault(mis_fault),
    .mem_req_stb(mem_req_stb), .mem_req_addr(mem_req_addr), .mem_req_ack(mem_req_ack),
    .mem_rsp_stb(mem_rsp_stb), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .wr_ena(wr_ena), .wr_tid(wr_tid), .wr_page(wr_page), .wr_descriptor(wr_descriptor),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int          checks = 0;
  int          passes = 0;
  logic [W-1:0] exp_q[$];
  logic        mis_q[$];
  int          exp_flush_acks = 0;
  int          obs_flush_acks = 0;
  logic [35:0] last_desc = '0;
  logic [31:0] last_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: expected event missing or unexpected event seen", name);
  endtask

  function automatic logic [W-1:0] flush_entry(input int i);
    return {5'(i >> 1), 1'(i & 1), 36'd0};
  endfunction

  task automatic push_flush();
    for (int i = 0; i < 64; i++) exp_q.push_back(flush_entry(i));
  endtask

  // compare process
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_ena) begin
          if (exp_q.size() == 0) fail_now("unexpected_write");
          else chk("table_write", 64'({wr_page, wr_tid, wr_descriptor}), 64'(exp_q.pop_front()));
          last_desc = wr_descriptor;
        end
        if (mis_ack) begin
          if (mis_q.size() == 0) fail_now("unexpected_mis_ack");
          else chk("mis_fault", 64'(mis_fault), 64'(mis_q.pop_front()));
          chk("ack_with_write", 64'(wr_ena), 64'd1);
        end else if (mis_fault) begin
          fail_now("fault_without_ack");
        end
        if (flush_ack) obs_flush_acks++;
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("idle_timeout");
    repeat (3) @(negedge clk);
    chk("flush_ack_count", 64'(obs_flush_acks), 64'(exp_flush_acks));
  endtask

  task automatic do_flush();
    bit seen = 1'b0;
    push_flush();
    exp_flush_acks++;
    flush_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (flush_ack) begin
        seen = 1'b1;
        break;
      end
    end
    flush_req = 1'b0;
    if (!seen) fail_now("flush_ack_timeout");
    wait_idle();
  endtask

  // mode 0: plain fill, 1: flush pulsed during WAIT, 2: flush and miss together in IDLE
  task automatic do_miss(input logic tid, input logic [4:0] page, input logic err,
                         input logic [35:0] data, input int mode);
    logic [31:0] exp_addr;
    int          n;
    bit          seen;
    bit          early;
    exp_addr = cfg_pt_base + (32'(page) * 2 + 32'(tid)) * 8;
    if (mode == 2) begin
      push_flush();
      exp_flush_acks++;
    end
    exp_q.push_back({page, tid, err ? 36'd0 : data});
    mis_q.push_back(err);
    if (mode == 1) begin
      push_flush();
      exp_flush_acks++;
    end
    mis_tid  = tid;
    mis_page = page;
    mis_stb  = 1'b1;
    if (mode == 2) begin
      flush_req = 1'b1;
      seen  = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 120; i++) begin
        @(negedge clk);
        if (mem_req_stb) early = 1'b1;
        if (flush_ack) begin
          seen = 1'b1;
          break;
        end
      end
      flush_req = 1'b0;
      if (!seen) fail_now("flush_ack_timeout");
      chk("req_before_flush_ack", 64'(early), 64'd0);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req_stb) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now("mem_req_timeout");
      mis_stb = 1'b0;
      return;
    end
    chk("mem_req_addr", 64'(mem_req_addr), 64'(exp_addr));
    last_addr = mem_req_addr;
    n = $urandom_range(0, 2);
    repeat (n) @(negedge clk);
    chk("req_held", 64'(mem_req_stb), 64'd1);
    mem_req_ack = 1'b1;
    @(negedge clk);
    mem_req_ack = 1'b0;
    chk("req_drop", 64'(mem_req_stb), 64'd0);
    mis_tid  = 1'($urandom());
    mis_page = 5'($urandom());
    if (mode == 1) begin
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
    end
    n = $urandom_range(0, 3);
    repeat (n) @(negedge clk);
    mem_rsp_stb  = 1'b1;
    mem_rsp_data = data;
    mem_rsp_err  = err;
    @(negedge clk);
    mem_rsp_stb  = 1'b0;
    mem_rsp_data = 36'($urandom());
    mem_rsp_err  = 1'($urandom());
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mis_ack) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) fail_now("mis_ack_timeout");
    mis_stb = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset_mid_fill();
    bit seen = 1'b0;
    mis_tid  = 1'($urandom());
    mis_page = 5'($urandom());
    mis_stb  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req_stb) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("mem_req_timeout_rst");
    mem_req_ack = 1'b1;
    @(negedge clk);
    mem_req_ack = 1'b0;
    rst     = 1'b1;
    mis_stb = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_wr_ena", 64'(wr_ena), 64'd0);
    chk("rst_mem_req", 64'(mem_req_stb), 64'd0);
    push_flush();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mem_rsp_stb  = 1'b1;
    mem_rsp_data = 36'h5_5555_5555;
    @(negedge clk);
    mem_rsp_stb  = 1'b0;
    wait_idle();
  endtask

  // main sequence
  initial begin
    int wr_cnt;
    int ack_cnt;
    logic busy_64;
    logic busy_65;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_wr_ena", 64'(wr_ena), 64'd0);
    chk("reset_flush_ack", 64'(flush_ack), 64'd0);
    chk("reset_mis_ack", 64'(mis_ack), 64'd0);
    chk("reset_mem_req", 64'(mem_req_stb), 64'd0);
    push_flush();
    rst = 1'b0;

    wr_cnt  = 0;
    ack_cnt = 0;
    busy_64 = 1'b0;
    busy_65 = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (wr_ena && k <= 64) wr_cnt++;
      if (flush_ack) ack_cnt++;
      if (k == 64) busy_64 = busy;
      if (k == 65) busy_65 = busy;
    end
    chk("sweep_writes", 64'(wr_cnt), 64'd64);
    chk("sweep_busy_last_write", 64'(busy_64), 64'd1);
    chk("sweep_busy_drop", 64'(busy_65), 64'd0);
    chk("sweep_no_ack", 64'(ack_cnt), 64'd0);
    wait_idle();

    cfg_pt_base = 32'h1000;
    do_miss(1'b1, 5'd5, 1'b0, 36'h9_ABCD_1234, 0);
    chk("pin_addr", 64'(last_addr), 64'h1058);
    chk("pin_desc", 64'(last_desc), 64'h9_ABCD_1234);

    do_miss(1'b1, 5'd5, 1'b1, 36'h9_ABCD_1234, 0);
    chk("pin_err_desc", 64'(last_desc), 64'd0);

    do_miss(1'b0, 5'd17, 1'b0, 36'h1_2345_6789, 1);
    do_miss(1'b1, 5'd31, 1'b0, 36'hF_FFFF_FFFF, 2);
    do_flush();
    do_reset_mid_fill();

    for (int it = 0; it < 24; it++) begin
      if (it % 6 == 0) cfg_pt_base = 32'hFFFF_FFF8;
      else cfg_pt_base = $urandom() & 32'hFFFF_FFF8;
      if ($urandom_range(0, 7) == 0) do_flush();
      do_miss(1'($urandom()), 5'($urandom()), ($urandom_range(0, 3) == 0),
              {4'($urandom()), 32'($urandom())}, $urandom_range(0, 2));
    end

    chk("final_writes_drained", 64'(exp_q.size()), 64'd0);
    chk("final_acks_drained", 64'(mis_q.size()), 64'd0);
    chk("final_flush_acks", 64'(obs_flush_acks), 64'(exp_flush_acks));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
